// File: rtl/rf_wr_arbiter_if.sv
// Bundle of handshake, scoreboard and register-file write-port signals for rf_wr_arbiter.
// slave is the arbiter's view; master is the requester/decode side.
interface rf_wr_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              init_start;
    logic              init_busy;

    logic              wb_req;
    logic [1:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_gnt;

    logic              dbg_req;
    logic [1:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_gnt;

    logic              sb_set;
    logic [1:0]        sb_addr;
    logic [1:0]        rs1_addr;
    logic [1:0]        rs2_addr;
    logic              hazard;
    logic [3:0]        pending;

    logic              rf_write;
    logic [1:0]        rf_addr3;
    logic [DATA_W-1:0] rf_data3;

    modport slave (
        input  init_start,
        output init_busy,
        input  wb_req, wb_addr, wb_data,
        output wb_gnt,
        input  dbg_req, dbg_addr, dbg_data,
        output dbg_gnt,
        input  sb_set, sb_addr, rs1_addr, rs2_addr,
        output hazard, pending,
        output rf_write, rf_addr3, rf_data3
    );

    modport master (
        output init_start,
        input  init_busy,
        output wb_req, wb_addr, wb_data,
        input  wb_gnt,
        output dbg_req, dbg_addr, dbg_data,
        input  dbg_gnt,
        output sb_set, sb_addr, rs1_addr, rs2_addr,
        input  hazard, pending,
        input  rf_write, rf_addr3, rf_data3
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: round-robin between writeback and debug loader,
// a 4-entry pending-writeback scoreboard, and an init sequence that clears all registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | normal operation: arbitrate requests, track scoreboard
// ST_INIT | write INIT_VAL to registers 0..3, one per cycle, no grants
module rf_wr_arbiter #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    rf_wr_arbiter_if.slave   arb_io
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [3:0]        pending_q;
    logic [3:0]        pending_d;
    logic              rr_q;
    logic              rf_write_q;
    logic [1:0]        rf_addr_q;
    logic [DATA_W-1:0] rf_data_q;

    logic in_run;
    logic start_init;
    logic arb_ok;
    logic wb_gnt_c;
    logic dbg_gnt_c;

    assign in_run     = (state_q == ST_RUN);
    assign start_init = in_run & arb_io.init_start;
    assign arb_ok     = in_run & ~rst & ~arb_io.init_start;

    // rr_q set means writeback won most recently, so debug is favoured on a tie.
    assign wb_gnt_c  = arb_ok & arb_io.wb_req  & (~arb_io.dbg_req | ~rr_q);
    assign dbg_gnt_c = arb_ok & arb_io.dbg_req & (~arb_io.wb_req  |  rr_q);

    always_comb begin
        pending_d = pending_q;
        if (start_init) begin
            pending_d = '0;
        end else if (in_run) begin
            if (wb_gnt_c)
                pending_d[arb_io.wb_addr] = 1'b0;
            // Set applied after clear so a same-cycle set wins.
            if (arb_io.sb_set)
                pending_d[arb_io.sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 2'd0;
            pending_q  <= 4'b0000;
            rr_q       <= 1'b0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= 2'd0;
            rf_data_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            rf_write_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (arb_io.init_start) begin
                        state_q <= ST_INIT;
                        cnt_q   <= 2'd0;
                    end else if (wb_gnt_c) begin
                        rf_write_q <= 1'b1;
                        rf_addr_q  <= arb_io.wb_addr;
                        rf_data_q  <= arb_io.wb_data;
                        rr_q       <= 1'b1;
                    end else if (dbg_gnt_c) begin
                        rf_write_q <= 1'b1;
                        rf_addr_q  <= arb_io.dbg_addr;
                        rf_data_q  <= arb_io.dbg_data;
                        rr_q       <= 1'b0;
                    end
                end
                ST_INIT: begin
                    rf_write_q <= 1'b1;
                    rf_addr_q  <= cnt_q;
                    rf_data_q  <= INIT_VAL;
                    cnt_q      <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign arb_io.init_busy = (state_q == ST_INIT);
    assign arb_io.wb_gnt    = wb_gnt_c;
    assign arb_io.dbg_gnt   = dbg_gnt_c;
    assign arb_io.pending   = pending_q;
    assign arb_io.hazard    = (state_q == ST_INIT)
                            | pending_q[arb_io.rs1_addr]
                            | pending_q[arb_io.rs2_addr];
    assign arb_io.rf_write  = rf_write_q;
    assign arb_io.rf_addr3  = rf_addr_q;
    assign arb_io.rf_data3  = rf_data_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized and directed bench for rf_wr_arbiter against a cycle-level behavioural model.
module tb_rf_wr_arbiter;

    localparam int          DW   = 16;
    localparam logic [15:0] INIT = 16'h5A3C;

    logic clk;
    logic rst;
    rf_wr_arbiter_if #(.DATA_W(DW)) bus ();

    rf_wr_arbiter #(.DATA_W(DW), .INIT_VAL(INIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: remaining init writes, scoreboard, who won last, expected write port.
    int          m_left;
    bit   [3:0]  m_pend;
    bit          m_last_wb;
    bit          m_wr;
    bit   [1:0]  m_addr;
    bit   [15:0] m_data;

    bit g_wb, g_dbg;
    bit obs_wb, obs_dbg, obs_haz, obs_busy;
    bit wb_hold, dbg_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left    = 0;
        m_pend    = 4'b0000;
        m_last_wb = 1'b0;
        m_wr      = 1'b0;
        m_addr    = 2'd0;
        m_data    = 16'h0000;
        wb_hold   = 1'b0;
        dbg_hold  = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.init_start = 1'b0;
        bus.wb_req     = 1'b0;
        bus.dbg_req    = 1'b0;
        bus.sb_set     = 1'b0;
    endtask

    // Called just after a posedge with inputs already driven; returns just after the next posedge.
    task automatic step();
        bit busy, p_wb, p_dbg, p_haz;
        busy  = (m_left > 0);
        p_wb  = 1'b0;
        p_dbg = 1'b0;
        if (!busy && !bus.init_start) begin
            if (bus.wb_req && bus.dbg_req) begin
                p_wb  = !m_last_wb;
                p_dbg = m_last_wb;
            end else begin
                p_wb  = bus.wb_req;
                p_dbg = bus.dbg_req;
            end
        end
        p_haz = busy || m_pend[bus.rs1_addr] || m_pend[bus.rs2_addr];

        @(negedge clk);
        obs_wb   = bus.wb_gnt;
        obs_dbg  = bus.dbg_gnt;
        obs_haz  = bus.hazard;
        obs_busy = bus.init_busy;
        chk("wb_gnt",    32'(obs_wb),       32'(p_wb));
        chk("dbg_gnt",   32'(obs_dbg),      32'(p_dbg));
        chk("init_busy", 32'(obs_busy),     32'(busy));
        chk("hazard",    32'(obs_haz),      32'(p_haz));
        chk("pending",   32'(bus.pending),  32'(m_pend));
        chk("rf_write",  32'(bus.rf_write), 32'(m_wr));
        chk("rf_addr3",  32'(bus.rf_addr3), 32'(m_addr));
        chk("rf_data3",  32'(bus.rf_data3), 32'(m_data));

        if (busy) begin
            m_wr   = 1'b1;
            m_addr = 2'(4 - m_left);
            m_data = INIT;
            m_left = m_left - 1;
        end else if (bus.init_start) begin
            m_left = 4;
            m_pend = 4'b0000;
            m_wr   = 1'b0;
        end else begin
            m_wr = 1'b0;
            if (p_wb) begin
                m_wr      = 1'b1;
                m_addr    = bus.wb_addr;
                m_data    = bus.wb_data;
                m_last_wb = 1'b1;
                m_pend[bus.wb_addr] = 1'b0;
            end else if (p_dbg) begin
                m_wr      = 1'b1;
                m_addr    = bus.dbg_addr;
                m_data    = bus.dbg_data;
                m_last_wb = 1'b0;
            end
            if (bus.sb_set)
                m_pend[bus.sb_addr] = 1'b1;
        end
        g_wb  = p_wb;
        g_dbg = p_dbg;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset with both requesters asserting; nothing may be granted or written.
    task automatic do_reset();
        bus.wb_req  = 1'b1;
        bus.dbg_req = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_rf_write",  32'(bus.rf_write),  32'd0);
        chk("rst_pending",   32'(bus.pending),   32'd0);
        chk("rst_init_busy", 32'(bus.init_busy), 32'd0);
        chk("rst_wb_gnt",    32'(bus.wb_gnt),    32'd0);
        chk("rst_dbg_gnt",   32'(bus.dbg_gnt),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        bus.wb_addr  = 2'd0;
        bus.wb_data  = '0;
        bus.dbg_addr = 2'd0;
        bus.dbg_data = '0;
        bus.sb_addr  = 2'd0;
        bus.rs1_addr = 2'd0;
        bus.rs2_addr = 2'd0;
        #2;
        do_reset();
        chk("rst_rf_addr3", 32'(bus.rf_addr3), 32'd0);
        chk("rst_rf_data3", 32'(bus.rf_data3), 32'd0);

        // Single writeback request right after reset.
        bus.wb_req = 1'b1; bus.wb_addr = 2'd2; bus.wb_data = 16'hBEEF;
        step();
        chk("d_wb_same_cycle", 32'(obs_wb), 32'd1);
        idle_inputs();
        chk("d_wb_rf_write", 32'(bus.rf_write), 32'd1);
        chk("d_wb_rf_addr",  32'(bus.rf_addr3), 32'd2);
        chk("d_wb_rf_data",  32'(bus.rf_data3), 32'hBEEF);
        step();

        // Debug-only write leaves debug as last winner, then a tie for 4 cycles alternates WB first.
        bus.dbg_req = 1'b1; bus.dbg_addr = 2'd3; bus.dbg_data = 16'h1234;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.wb_req  = 1'b1; bus.wb_addr  = 2'(i);     bus.wb_data  = 16'(16'hA000 + i);
            bus.dbg_req = 1'b1; bus.dbg_addr = 2'(3 - i); bus.dbg_data = 16'(16'hD000 + i);
            step();
            chk("d_rr_wb",  32'(obs_wb),  32'((i % 2) == 0));
            chk("d_rr_dbg", 32'(obs_dbg), 32'((i % 2) == 1));
        end
        idle_inputs();
        step();

        // Scoreboard set, hazard, clear by writeback, and set-wins collision.
        bus.sb_set = 1'b1; bus.sb_addr = 2'd1;
        step();
        bus.sb_set = 1'b0; bus.rs1_addr = 2'd1; bus.rs2_addr = 2'd0;
        step();
        chk("d_sb_hazard", 32'(obs_haz), 32'd1);
        bus.wb_req = 1'b1; bus.wb_addr = 2'd1; bus.wb_data = 16'h0111;
        step();
        bus.wb_req = 1'b0;
        step();
        chk("d_sb_clear_haz", 32'(obs_haz), 32'd0);
        chk("d_sb_clear_pend", 32'(bus.pending[1]), 32'd0);
        bus.sb_set = 1'b1; bus.sb_addr = 2'd1;
        bus.wb_req = 1'b1; bus.wb_addr = 2'd1; bus.wb_data = 16'h0222;
        step();
        idle_inputs();
        chk("d_sb_set_wins", 32'(bus.pending[1]), 32'd1);
        step();

        // Init sequence with a writeback request waiting the whole time.
        bus.init_start = 1'b1;
        bus.wb_req = 1'b1; bus.wb_addr = 2'd3; bus.wb_data = 16'h3333;
        step();
        bus.init_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) bus.init_start = 1'b1;
            step();
            bus.init_start = 1'b0;
            chk("d_init_busy",   32'(obs_busy), 32'd1);
            chk("d_init_hazard", 32'(obs_haz),  32'd1);
            chk("d_init_no_gnt", 32'(obs_wb),   32'd0);
            chk("d_init_addr",   32'(bus.rf_addr3), 32'(i));
            chk("d_init_data",   32'(bus.rf_data3), 32'(INIT));
        end
        step();
        chk("d_init_after_gnt", 32'(obs_wb), 32'd1);
        idle_inputs();
        step();

        // Reset in the second init cycle aborts the sequence; WB favoured afterwards.
        bus.dbg_req = 1'b1; bus.dbg_addr = 2'd0; bus.dbg_data = 16'h0AAA;
        step();
        idle_inputs();
        bus.init_start = 1'b1;
        step();
        bus.init_start = 1'b0;
        step();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        bus.wb_req  = 1'b1; bus.wb_addr  = 2'd1; bus.wb_data  = 16'h7777;
        bus.dbg_req = 1'b1; bus.dbg_addr = 2'd2; bus.dbg_data = 16'h8888;
        step();
        chk("d_post_rst_wb", 32'(obs_wb), 32'd1);
        idle_inputs();
        step();

        // Randomized traffic following the hold-until-grant protocol.
        for (int n = 0; n < 2000; n++) begin
            if (!wb_hold) begin
                bus.wb_req  = 1'($urandom_range(1, 0));
                bus.wb_addr = 2'($urandom_range(3, 0));
                bus.wb_data = 16'($urandom);
            end
            if (!dbg_hold) begin
                bus.dbg_req  = 1'($urandom_range(1, 0));
                bus.dbg_addr = 2'($urandom_range(3, 0));
                bus.dbg_data = 16'($urandom);
            end
            bus.init_start = ($urandom_range(39, 0) == 0);
            bus.sb_set     = ($urandom_range(2, 0) == 0);
            bus.sb_addr    = 2'($urandom_range(3, 0));
            bus.rs1_addr   = 2'($urandom_range(3, 0));
            bus.rs2_addr   = 2'($urandom_range(3, 0));
            if ($urandom_range(299, 0) == 0) begin
                do_reset();
            end else begin
                step();
                wb_hold  = bus.wb_req  && !g_wb;
                dbg_hold = bus.dbg_req && !g_dbg;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of register data words.
REQ-002 Parameter INIT_VAL, default 16'h0000, value written to every register by the init sequence.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 init_start  input  1  one-cycle pulse requesting a clear of all 4 registers.
REQ-006 init_busy  output  1  high while the init sequence runs.
REQ-007 wb_req / wb_addr / wb_data  input  1 / 2 / DATA_W  writeback write request, destination, data.
REQ-008 wb_gnt  output  1  writeback request accepted this cycle.
REQ-009 dbg_req / dbg_addr / dbg_data  input  1 / 2 / DATA_W  debug-loader write request, destination, data.
REQ-010 dbg_gnt  output  1  debug request accepted this cycle.
REQ-011 sb_set / sb_addr  input  1 / 2  issue stage marks register sb_addr as pending a writeback.
REQ-012 rs1_addr / rs2_addr  input  2 / 2  source registers of the instruction in decode.
REQ-013 hazard  output  1  decode must stall.
REQ-014 pending  output  4  scoreboard, bit i = register i awaits writeback.
REQ-015 rf_write / rf_addr3 / rf_data3  output  1 / 2 / DATA_W  registered drive of the register-file write port.

Function
REQ-016 FSM has two states, RUN and INIT; reset enters RUN.
REQ-017 RUN + init_start: next state INIT, 2-bit counter cnt=0, all pending bits cleared, no grant that cycle.
REQ-018 INIT: each cycle rf_write=1, rf_addr3=cnt, rf_data3=INIT_VAL on the next edge; cnt increments; after cnt=3 is issued, state returns to RUN (exactly 4 write cycles).
REQ-019 init_busy = (state==INIT), combinational from state.
REQ-020 init_start while in INIT is ignored; the sequence does not restart.
REQ-021 In INIT wb_gnt=dbg_gnt=0, and sb_set is ignored.
REQ-022 RUN, single requester: its gnt is asserted combinationally in the same cycle.
REQ-023 RUN, both requesters: grant goes to the one not granted most recently (round-robin flag rr); rr updates on every grant.
REQ-024 At most one gnt is high per cycle.
REQ-025 Requester holds req/addr/data stable until it sees gnt; it may deassert or present a new request on the cycle after gnt.
REQ-026 Write latency: grant in cycle N -> rf_write=1 with that addr/data registered at edge ending N, visible in cycle N+1; no grant -> rf_write=0 next cycle.
REQ-027 Throughput is one write per cycle; back-to-back grants are allowed.
REQ-028 Scoreboard set: sb_set in RUN sets pending[sb_addr] at the clock edge.
REQ-029 Scoreboard clear: wb_gnt clears pending[wb_addr]; dbg_gnt never clears pending.
REQ-030 Same-cycle set and clear of the same address: set wins (bit stays 1).
REQ-031 hazard = init_busy | pending[rs1_addr] | pending[rs2_addr], combinational.
REQ-032 rf_addr3/rf_data3 hold their last values when rf_write=0.

Reset
REQ-033 reset asserted: immediately state=RUN, cnt=0, pending=4'b0000, rf_write=0, rf_addr3=0, rf_data3=0, rr favours WB.
REQ-034 reset during INIT aborts the sequence; no further init writes occur after reset deasserts.
REQ-035 wb_gnt, dbg_gnt and init_busy are 0 while reset is high.

Verification
REQ-036 Release reset, wb_req=1 wb_addr=2 wb_data=16'hBEEF -> wb_gnt=1 same cycle; next cycle rf_write=1, rf_addr3=2, rf_data3=16'hBEEF.
REQ-037 wb_req and dbg_req held high for 4 cycles -> grant order WB, DBG, WB, DBG; exactly one gnt per cycle.
REQ-038 sb_set addr=1, then rs1_addr=1 -> hazard=1; wb grant to addr 1 -> pending[1]=0 and hazard=0 next cycle; same-cycle sb_set=1 addr=1 and wb grant addr=1 -> pending[1] stays 1.
REQ-039 init_start with wb_req=1 -> 4 writes of INIT_VAL to addr 0,1,2,3, init_busy=1 and hazard=1 for 4 cycles, wb_gnt only after return to RUN.
REQ-040 Assert reset in the 2nd INIT cycle -> rf_write=0 and pending=0 at once; after release, no further init writes and grants resume with WB favoured.
